// File: rtl/node_pkg.sv
// Shared types and constants for the node_port network interface.
package node_pkg;

    localparam int PKT_BYTES = 4;
    localparam int BYTE_W    = 8;

    typedef struct packed {
        logic [7:0]  tag;
        logic [3:0]  src;
        logic [3:0]  dest;
        logic [15:0] data;
    } pkt_t;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_EMPTY = 2'd0,
        RX_FILL  = 2'd1,
        RX_FULL  = 2'd2
    } rx_state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/node_port_pkt_fifo.sv
// pkt_fifo: small synchronous FIFO with registered occupancy count.
// Pushes while full and pops while empty are ignored.
module pkt_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/node_port.sv
// node_port: buffers 32-bit packets from the core and serializes them onto the
// router's byte link; reassembles inbound bytes. Optional counters: NODE_PORT_STATS_EN.
module node_port
    import node_pkg::*;
#(
    parameter logic [3:0] NODEID     = 4'd0,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] tx_pkt,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [31:0] rx_pkt,
    output logic        rx_valid,
    input  logic        rx_ack,
    input  logic        free_outbound,
    output logic        put_outbound,
    output logic [7:0]  payload_outbound,
    output logic        free_inbound,
    input  logic        put_inbound,
    input  logic [7:0]  payload_inbound,
    output logic        rx_err,
    output logic [15:0] tx_count,
    output logic [15:0] rx_count
);

    localparam int         CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [1:0] LAST_BYTE = 2'(PKT_BYTES - 1);

    // Handshakes: core->fifo transfers on tx_valid && tx_ready; rx_pkt is held
    // with rx_valid until rx_ack; on the link a sender that saw free high drives
    // put for exactly PKT_BYTES consecutive cycles, MSB byte first, payload 0 otherwise.
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   fifo_head;
    logic          fifo_push;
    logic          fifo_pop;

    tx_state_t     tx_state;
    logic [1:0]    tx_idx;
    logic [23:0]   tx_shreg;

    rx_state_t     rx_state;
    logic [1:0]    rx_cnt;
    logic [23:0]   rx_shreg;
    pkt_t          rx_word;

    assign fifo_push = tx_valid && !fifo_full;
    assign tx_ready  = (fifo_count != CW'(FIFO_DEPTH));
    assign fifo_pop  = (tx_state == TX_IDLE) && !fifo_empty && free_outbound;
    assign rx_word   = {rx_shreg, payload_inbound};

    pkt_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (tx_pkt),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // The head byte is emitted on the loading edge; the shift register keeps the rest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state         <= TX_IDLE;
            tx_idx           <= '0;
            tx_shreg         <= '0;
            put_outbound     <= 1'b0;
            payload_outbound <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (fifo_pop) begin
                        tx_state         <= TX_SEND;
                        tx_idx           <= '0;
                        tx_shreg         <= fifo_head[23:0];
                        put_outbound     <= 1'b1;
                        payload_outbound <= fifo_head[31:24];
                    end
                end
                TX_SEND: begin
                    if (tx_idx == LAST_BYTE) begin
                        tx_state         <= TX_IDLE;
                        put_outbound     <= 1'b0;
                        payload_outbound <= '0;
                    end else begin
                        tx_idx           <= tx_idx + 2'd1;
                        payload_outbound <= tx_shreg[23:16];
                        tx_shreg         <= {tx_shreg[15:0], 8'h00};
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state     <= RX_EMPTY;
            rx_cnt       <= '0;
            rx_shreg     <= '0;
            rx_pkt       <= '0;
            rx_valid     <= 1'b0;
            free_inbound <= 1'b1;
            rx_err       <= 1'b0;
        end else begin
            rx_err <= 1'b0;
            case (rx_state)
                RX_EMPTY: begin
                    if (put_inbound) begin
                        rx_shreg     <= {rx_shreg[15:0], payload_inbound};
                        rx_cnt       <= 2'd1;
                        rx_state     <= RX_FILL;
                        free_inbound <= 1'b0;
                    end
                end
                RX_FILL: begin
                    if (!put_inbound) begin
                        rx_err       <= 1'b1;
                        rx_cnt       <= '0;
                        rx_state     <= RX_EMPTY;
                        free_inbound <= 1'b1;
                    end else if (rx_cnt == LAST_BYTE) begin
                        rx_pkt   <= rx_word;
                        rx_valid <= 1'b1;
                        rx_cnt   <= '0;
                        rx_state <= RX_FULL;
                    end else begin
                        rx_shreg <= {rx_shreg[15:0], payload_inbound};
                        rx_cnt   <= rx_cnt + 2'd1;
                    end
                end
                RX_FULL: begin
                    // A byte arriving while the core still owns rx_pkt is a sender error.
                    if (put_inbound) rx_err <= 1'b1;
                    if (rx_ack) begin
                        rx_valid     <= 1'b0;
                        free_inbound <= 1'b1;
                        rx_state     <= RX_EMPTY;
                    end
                end
                default: begin
                    rx_state     <= RX_EMPTY;
                    free_inbound <= 1'b1;
                    rx_valid     <= 1'b0;
                end
            endcase
        end
    end

`ifdef NODE_PORT_STATS_EN
    logic        tx_done;
    logic        rx_done;
    logic [15:0] tx_cnt_q;
    logic [15:0] rx_cnt_q;

    assign tx_done = (tx_state == TX_SEND) && (tx_idx == LAST_BYTE);
    assign rx_done = (rx_state == RX_FILL) && put_inbound && (rx_cnt == LAST_BYTE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (tx_done) tx_cnt_q <= sat_inc(tx_cnt_q);
            if (rx_done && (rx_word.dest == NODEID)) rx_cnt_q <= sat_inc(rx_cnt_q);
        end
    end

    assign tx_count = tx_cnt_q;
    assign rx_count = rx_cnt_q;
`else
    assign tx_count = '0;
    assign rx_count = '0;
`endif

endmodule

// File: tb/tb_node_port.sv
// Directed bench for node_port: TX serialization, FIFO backpressure, RX
// reassembly and error cases, reset mid-packet, and the optional counters.
module tb_node_port;

    localparam logic [3:0] NODE_ID = 4'h4;
    localparam int         DEPTH   = 4;
`ifdef NODE_PORT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] tx_pkt;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] rx_pkt;
    logic        rx_valid;
    logic        rx_ack;
    logic        free_outbound;
    logic        put_outbound;
    logic [7:0]  payload_outbound;
    logic        free_inbound;
    logic        put_inbound;
    logic [7:0]  payload_inbound;
    logic        rx_err;
    logic [15:0] tx_count;
    logic [15:0] rx_count;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];

    node_port #(
        .NODEID     (NODE_ID),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .tx_pkt           (tx_pkt),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .rx_pkt           (rx_pkt),
        .rx_valid         (rx_valid),
        .rx_ack           (rx_ack),
        .free_outbound    (free_outbound),
        .put_outbound     (put_outbound),
        .payload_outbound (payload_outbound),
        .free_inbound     (free_inbound),
        .put_inbound      (put_inbound),
        .payload_inbound  (payload_inbound),
        .rx_err           (rx_err),
        .tx_count         (tx_count),
        .rx_count         (rx_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [31:0] p);
        tx_pkt   = p;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
    endtask

    task automatic rx_bytes(input logic [31:0] p, input int n);
        for (int i = 0; i < n; i++) begin
            put_inbound     = 1'b1;
            payload_inbound = p[31-8*i -: 8];
            step();
            check_eq("rx_free_busy", {31'd0, free_inbound}, 32'd0);
        end
        put_inbound     = 1'b0;
        payload_inbound = 8'h00;
    endtask

    task automatic ack_rx();
        rx_ack = 1'b1;
        step();
        rx_ack = 1'b0;
    endtask

    logic [31:0] t1_pkt;
    logic [31:0] t2_pkts [4];
    int          run_len;
    int          pkts_seen;
    logic        any_put;

    initial begin
        rst = 1'b1; tx_pkt = '0; tx_valid = 1'b0; rx_ack = 1'b0;
        free_outbound = 1'b0; put_inbound = 1'b0; payload_inbound = '0;
        step();
        step();
        check_eq("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check_eq("rst_put", {31'd0, put_outbound}, 32'd0);
        check_eq("rst_payload", {24'd0, payload_outbound}, 32'd0);
        check_eq("rst_free_in", {31'd0, free_inbound}, 32'd1);
        check_eq("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check_eq("rst_rx_pkt", rx_pkt, 32'd0);
        check_eq("rst_rx_err", {31'd0, rx_err}, 32'd0);
        check_eq("rst_tx_count", {16'd0, tx_count}, 32'd0);
        check_eq("rst_rx_count", {16'd0, rx_count}, 32'd0);
        rst = 1'b0;
        step();

        // single packet: bytes appear after the edge following the push edge
        free_outbound = 1'b1;
        t1_pkt = 32'hA1B2C3D4;
        push_tx(t1_pkt);
        check_eq("t1_idle_after_push", {31'd0, put_outbound}, 32'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            check_eq("t1_put", {31'd0, put_outbound}, 32'd1);
            check_eq("t1_byte", {24'd0, payload_outbound}, {24'd0, t1_pkt[31-8*i -: 8]});
            step();
        end
        check_eq("t1_put_end", {31'd0, put_outbound}, 32'd0);
        check_eq("t1_payload_end", {24'd0, payload_outbound}, 32'd0);
        check_eq("t1_tx_count", {16'd0, tx_count}, STATS ? 32'd1 : 32'd0);

        // fill FIFO with link blocked, drop one push, then drain in order
        free_outbound = 1'b0;
        t2_pkts[0] = 32'h11223344; t2_pkts[1] = 32'h55667788;
        t2_pkts[2] = 32'h99AABBCC; t2_pkts[3] = 32'h0F1E2D3C;
        for (int i = 0; i < DEPTH; i++) begin
            check_eq("t2_ready_before_full", {31'd0, tx_ready}, 32'd1);
            push_tx(t2_pkts[i]);
            for (int b = 0; b < 4; b++) exp_q.push_back(t2_pkts[i][31-8*b -: 8]);
        end
        check_eq("t2_full", {31'd0, tx_ready}, 32'd0);
        push_tx(32'hDEADBEEF);
        check_eq("t2_still_full", {31'd0, tx_ready}, 32'd0);
        check_eq("t2_no_put_blocked", {31'd0, put_outbound}, 32'd0);
        free_outbound = 1'b1;
        run_len = 0;
        pkts_seen = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (put_outbound) begin
                if (exp_q.size() == 0) check_eq("t2_extra_byte", {24'd0, payload_outbound}, 32'hFFFF_FFFF);
                else check_eq("t2_byte", {24'd0, payload_outbound}, {24'd0, exp_q.pop_front()});
                run_len++;
            end else begin
                check_eq("t2_idle_payload", {24'd0, payload_outbound}, 32'd0);
                if (run_len != 0) begin
                    check_eq("t2_run_len", run_len, 32'd4);
                    pkts_seen++;
                end
                run_len = 0;
            end
        end
        check_eq("t2_queue_drained", exp_q.size(), 32'd0);
        check_eq("t2_pkts_seen", pkts_seen, 32'd4);
        check_eq("t2_ready_after", {31'd0, tx_ready}, 32'd1);
        check_eq("t2_tx_count", {16'd0, tx_count}, STATS ? 32'd5 : 32'd0);

        // RX reassembly, dest == NODE_ID
        check_eq("t3_free_idle", {31'd0, free_inbound}, 32'd1);
        rx_bytes(32'h12345678, 4);
        check_eq("t3_rx_valid", {31'd0, rx_valid}, 32'd1);
        check_eq("t3_rx_pkt", rx_pkt, 32'h12345678);
        check_eq("t3_rx_err", {31'd0, rx_err}, 32'd0);
        step();
        check_eq("t3_rx_valid_held", {31'd0, rx_valid}, 32'd1);
        check_eq("t3_rx_count", {16'd0, rx_count}, STATS ? 32'd1 : 32'd0);
        ack_rx();
        check_eq("t3_rx_valid_acked", {31'd0, rx_valid}, 32'd0);
        check_eq("t3_free_acked", {31'd0, free_inbound}, 32'd1);

        // byte arriving while full: error pulse, packet kept; dest != NODE_ID
        rx_bytes(32'h9A0BCDEF, 4);
        check_eq("t4_rx_valid", {31'd0, rx_valid}, 32'd1);
        put_inbound = 1'b1; payload_inbound = 8'h55;
        step();
        put_inbound = 1'b0; payload_inbound = 8'h00;
        check_eq("t4_err_pulse", {31'd0, rx_err}, 32'd1);
        check_eq("t4_valid_kept", {31'd0, rx_valid}, 32'd1);
        check_eq("t4_pkt_kept", rx_pkt, 32'h9A0BCDEF);
        step();
        check_eq("t4_err_clear", {31'd0, rx_err}, 32'd0);
        check_eq("t4_rx_count", {16'd0, rx_count}, STATS ? 32'd1 : 32'd0);
        ack_rx();

        // truncated packet
        rx_bytes(32'hAABB0000, 2);
        check_eq("t5_no_err_yet", {31'd0, rx_err}, 32'd0);
        step();
        check_eq("t5_err_pulse", {31'd0, rx_err}, 32'd1);
        check_eq("t5_rx_valid", {31'd0, rx_valid}, 32'd0);
        check_eq("t5_free_back", {31'd0, free_inbound}, 32'd1);
        step();
        check_eq("t5_err_once", {31'd0, rx_err}, 32'd0);
        ack_rx();
        check_eq("t5_ack_ignored_valid", {31'd0, rx_valid}, 32'd0);
        check_eq("t5_ack_ignored_free", {31'd0, free_inbound}, 32'd1);

        // second matching packet after the error recovers cleanly
        rx_bytes(32'hC0140001, 4);
        check_eq("t6_rx_pkt", rx_pkt, 32'hC0140001);
        check_eq("t6_rx_count", {16'd0, rx_count}, STATS ? 32'd2 : 32'd0);
        ack_rx();

        // reset during the third TX byte with a second packet still queued
        push_tx(32'h01020304);
        push_tx(32'h05060708);
        check_eq("t7_byte0", {24'd0, payload_outbound}, 32'h01);
        step();
        step();
        check_eq("t7_byte2", {24'd0, payload_outbound}, 32'h03);
        rst = 1'b1;
        #1;
        check_eq("t7_put_async", {31'd0, put_outbound}, 32'd0);
        check_eq("t7_payload_async", {24'd0, payload_outbound}, 32'd0);
        step();
        rst = 1'b0;
        any_put = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            any_put = any_put | put_outbound;
        end
        check_eq("t7_no_bytes_after", {31'd0, any_put}, 32'd0);
        check_eq("t7_tx_ready", {31'd0, tx_ready}, 32'd1);
        check_eq("t7_tx_count", {16'd0, tx_count}, 32'd0);
        check_eq("t7_rx_count", {16'd0, rx_count}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
